// File: rtl/sar_cmp_responder.sv
// Comparator/DAC responder for a SAR FSM: accepts a trial code, waits
// `settle` cycles, then holds a registered compare result until consumed.
// Params: WIDTH - code width.
// Ports: clk, rst_n (async low); sample/target latch the input value;
//   trial_valid/trial_ready/trial_code accept a trial; settle sets delay;
//   cmp_valid/cmp_ready/cmp_out return the decision; busy, trial_cnt.
// Option: CMP_DITHER_EN adds an 8-bit LFSR LSB dither to the target.
module sar_cmp_responder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample,
  input  logic [WIDTH-1:0] target,
  input  logic             trial_valid,
  input  logic [WIDTH-1:0] trial_code,
  output logic             trial_ready,
  input  logic [2:0]       settle,
  output logic             cmp_valid,
  output logic             cmp_out,
  input  logic             cmp_ready,
  output logic             busy,
  output logic [3:0]       trial_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    RESP
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] tgt_q;
  logic [WIDTH-1:0] code_q;
  logic [WIDTH-1:0] eff_q;
  logic [2:0]       cnt;

  logic [WIDTH-1:0] tgt_now;
  logic [WIDTH-1:0] eff;
  logic             hit;

  // A sample coinciding with the handshake already applies to that trial.
  assign tgt_now = sample ? target : tgt_q;

`ifdef CMP_DITHER_EN
  logic [7:0]     lfsr;
  logic [WIDTH:0] sum;

  assign sum = {1'b0, tgt_now} + {{WIDTH{1'b0}}, lfsr[0]};
  assign eff = sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 8'h01;
    end else if (state == IDLE && trial_valid) begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end
`else
  assign eff = tgt_now;
`endif

  assign hit = eff >= trial_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tgt_q       <= '0;
      code_q      <= '0;
      eff_q       <= '0;
      cnt         <= '0;
      cmp_valid   <= 1'b0;
      cmp_out     <= 1'b0;
      busy        <= 1'b0;
      trial_cnt   <= '0;
      trial_ready <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (sample) begin
            tgt_q     <= target;
            trial_cnt <= '0;
          end
          if (trial_valid) begin
            code_q      <= trial_code;
            eff_q       <= eff;
            cnt         <= settle;
            trial_ready <= 1'b0;
            busy        <= 1'b1;
            if (settle == 3'd0) begin
              state     <= RESP;
              cmp_valid <= 1'b1;
              cmp_out   <= hit;
            end else begin
              state <= SETTLE;
            end
          end
        end
        SETTLE: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            state     <= RESP;
            cmp_valid <= 1'b1;
            cmp_out   <= eff_q >= code_q;
          end
        end
        RESP: begin
          if (cmp_ready) begin
            state       <= IDLE;
            cmp_valid   <= 1'b0;
            cmp_out     <= 1'b0;
            busy        <= 1'b0;
            trial_ready <= 1'b1;
            if (trial_cnt != 4'hF) begin
              trial_cnt <= trial_cnt + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sar_cmp_responder.sv
// Randomized self-checking bench for sar_cmp_responder.
// Expected results come from a transaction-level model of the responder.
module tb_sar_cmp_responder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sample = 1'b0;
  logic [7:0] target = '0;
  logic       trial_valid = 1'b0;
  logic [7:0] trial_code = '0;
  logic       trial_ready;
  logic [2:0] settle = '0;
  logic       cmp_valid;
  logic       cmp_out;
  logic       cmp_ready = 1'b0;
  logic       busy;
  logic [3:0] trial_cnt;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] m_tgt;
  int         m_cnt;
  logic [7:0] m_lfsr;

  sar_cmp_responder #(.WIDTH(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sample(sample),
    .target(target),
    .trial_valid(trial_valid),
    .trial_code(trial_code),
    .trial_ready(trial_ready),
    .settle(settle),
    .cmp_valid(cmp_valid),
    .cmp_out(cmp_out),
    .cmp_ready(cmp_ready),
    .busy(busy),
    .trial_cnt(trial_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_tgt  = 8'h00;
    m_cnt  = 0;
    m_lfsr = 8'h01;
  endtask

  task automatic model_eval(input logic [7:0] code, output logic r);
    int e;
    e = m_tgt;
`ifdef CMP_DITHER_EN
    e = e + m_lfsr[0];
    if (e > 255) e = 255;
    m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
`endif
    r = (e >= code);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge, idle again.
  task automatic trial(input logic [7:0] code, input logic [2:0] st,
                       input int hold, input bit smp, input logic [7:0] stv,
                       input bit noise, output logic got);
    logic exp;
    int   lat;
    check("ready", trial_ready, 1);
    trial_valid = 1'b1;
    trial_code  = code;
    settle      = st;
    sample      = smp;
    target      = stv;
    if (smp) begin
      m_tgt = stv;
      m_cnt = 0;
    end
    model_eval(code, exp);
    @(negedge clk);
    trial_valid = 1'b0;
    sample      = 1'b0;
    trial_code  = 8'($urandom);
    settle      = 3'($urandom);
    if (smp) check("cnt_clr", trial_cnt, 0);
    lat = 1;
    while (!cmp_valid && lat <= 9) begin
      check("busy_wait", {busy, trial_ready}, 2'b10);
      if (noise) begin
        sample    = 1'b1;
        target    = 8'h10;
        cmp_ready = 1'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    sample    = 1'b0;
    cmp_ready = 1'b0;
    check("latency", lat, st + 1);
    check("cmp_out", cmp_out, exp);
    got = cmp_out;
    repeat (hold) begin
      if (noise) begin
        sample = 1'b1;
        target = 8'($urandom);
      end
      @(negedge clk);
      check("hold", {cmp_valid, cmp_out, trial_ready, busy},
            {1'b1, exp, 1'b0, 1'b1});
    end
    sample    = 1'b0;
    cmp_ready = 1'b1;
    @(negedge clk);
    cmp_ready = 1'b0;
    if (m_cnt < 15) m_cnt++;
    check("done", {cmp_valid, cmp_out, busy, trial_ready}, 4'b0001);
    check("trial_cnt", trial_cnt, m_cnt);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic       g;
    logic [7:0] res;
    int         lat;

    model_reset();
    repeat (2) @(negedge clk);
    check("rst_out", {trial_ready, cmp_valid, cmp_out, busy}, 4'b1000);
    check("rst_cnt", trial_cnt, 0);

    // Handshake on the very first edge after release.
    rst_n = 1'b1;
    trial(8'h80, 3'd0, 0, 1'b1, 8'h80, 1'b0, g);
    trial(8'h81, 3'd0, 0, 1'b0, 8'h00, 1'b0, g);

    // Long settle with a stalled consumer.
    trial(8'h33, 3'd5, 3, 1'b0, 8'h00, 1'b0, g);

    // Sample during SETTLE ignored; sample with handshake applied.
    trial(8'h7F, 3'd4, 1, 1'b0, 8'h00, 1'b1, g);
    trial(8'h20, 3'd2, 0, 1'b1, 8'h10, 1'b0, g);

    // Binary search.
    res = 8'h00;
    for (int b = 7; b >= 0; b--) begin
      logic [7:0] c;
      c = res | (8'h01 << b);
      trial(c, 3'($urandom), int'($urandom_range(0, 2)), b == 7, 8'hA5,
            1'b0, g);
      if (g) res = c;
    end
`ifndef CMP_DITHER_EN
    check("bs_code", res, 8'hA5);
`endif
    check("bs_cnt", trial_cnt, 8);
    check("bs_busy", busy, 0);

    // Top-of-range target, also drives trial_cnt into saturation.
    trial(8'hFF, 3'd1, 0, 1'b1, 8'hFF, 1'b0, g);
    repeat (16) trial(8'hFF, 3'($urandom), 0, 1'b0, 8'h00, 1'b0, g);
    trial(8'h41, 3'd0, 0, 1'b1, 8'h40, 1'b0, g);
    repeat (15) trial(8'h41, 3'($urandom), 0, 1'b0, 8'h00, 1'b0, g);

    // Random traffic.
    repeat (40) begin
      trial(8'($urandom), 3'($urandom), int'($urandom_range(0, 3)),
            ($urandom % 4) == 0, 8'($urandom), 1'($urandom), g);
    end

    // Reset while a response is pending.
    trial_valid = 1'b1;
    trial_code  = 8'h00;
    settle      = 3'd2;
    @(negedge clk);
    trial_valid = 1'b0;
    lat = 0;
    while (!cmp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("pre_rst_valid", cmp_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out", {cmp_valid, cmp_out, busy, trial_ready}, 4'b0001);
    check("arst_cnt", trial_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    trial(8'h00, 3'd0, 1, 1'b0, 8'h00, 1'b0, g);
    trial(8'h01, 3'd3, 0, 1'b0, 8'h00, 1'b0, g);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sar_cmp_responder.md
SAR_CMP_RESPONDER -- requirements
Module: sar_cmp_responder

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of target and trial codes.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1: reset, asynchronous and active-low.
REQ-004 SHALL have port sample  input  1: one-cycle strobe that latches target.
REQ-005 SHALL have port target  input  WIDTH: analog-equivalent input value to be converted.
REQ-006 SHALL have port trial_valid  input  1: SAR FSM presents a trial code.
REQ-007 SHALL have port trial_code  input  WIDTH: DAC trial code from the SAR FSM.
REQ-008 SHALL have port trial_ready  output  1: responder accepts a trial.
REQ-009 SHALL have port settle  input  3: comparator settling delay in cycles, 0..7.
REQ-010 SHALL have port cmp_valid  output  1: comparator result available.
REQ-011 SHALL have port cmp_out  output  1: comparator decision.
REQ-012 SHALL have port cmp_ready  input  1: SAR FSM consumes the result.
REQ-013 SHALL have port busy  output  1: high in SETTLE or RESP.
REQ-014 SHALL have port trial_cnt  output  4: completed responses since the last sample.

Function
REQ-015 SHALL implement states IDLE, SETTLE and RESP.
REQ-016 SHALL drive trial_ready=1 only in IDLE.
REQ-017 In IDLE, a handshake (trial_valid&trial_ready) SHALL capture trial_code and load the delay counter with settle.
REQ-018 On handshake, the state SHALL go to RESP if settle==0, else to SETTLE.
REQ-019 In SETTLE, the counter SHALL decrement each cycle and the state SHALL go to RESP in the cycle the counter reaches 1.
REQ-020 cmp_valid SHALL first assert exactly settle+1 cycles after the handshake cycle.
REQ-021 cmp_valid and cmp_out SHALL be asserted only in RESP and held stable until the cycle in which cmp_ready=1.
REQ-022 That cycle SHALL be the last RESP cycle: the state returns to IDLE and trial_cnt increments, saturating at 15.
REQ-023 cmp_out SHALL equal 1 iff effective target >= captured trial code, as an unsigned WIDTH-bit compare, evaluated at handshake.
REQ-024 sample SHALL latch target and clear trial_cnt only in IDLE; sample in SETTLE or RESP SHALL be ignored.
REQ-025 If sample and a handshake coincide in IDLE, the newly sampled target SHALL be used for that trial and trial_cnt SHALL restart from 0.
REQ-026 Changes to trial_code or settle after the handshake SHALL not affect the pending response.
REQ-027 cmp_ready asserted outside RESP SHALL be ignored.

Reset
REQ-028 rst_n low SHALL asynchronously force state IDLE, target reg 0, captured code 0, counter 0, cmp_valid 0, cmp_out 0, busy 0, trial_cnt 0 and trial_ready 1.
REQ-029 Reset asserted mid-SETTLE or mid-RESP SHALL abort the trial with no response.
REQ-030 After release, the first handshake SHALL be accepted at the first rising edge with rst_n high.

Configuration
REQ-031 Macro CMP_DITHER_EN SHALL control comparator dither.
REQ-032 With CMP_DITHER_EN defined:
- an 8-bit Fibonacci LFSR (taps 8,6,5,4, seed 0x01 at reset) SHALL advance once per handshake;
- effective target = target reg + lfsr[0], saturating at 2^WIDTH-1, using lfsr[0] before the advance.
REQ-033 Without CMP_DITHER_EN, the effective target SHALL equal the target reg, and no LFSR SHALL be present.

Verification
REQ-034 Reset, sample target=0x80, settle=0, trial 0x80 -> cmp_valid the next cycle, cmp_out=1; trial 0x81 -> cmp_out=0 (dither off).
REQ-035 settle=5, handshake at cycle T -> cmp_valid high at T+6, not before; cmp_ready held low 3 cycles -> cmp_out stable, trial_ready=0 throughout.
REQ-036 Full 8-trial binary search against target=0xA5 -> resolved code 0xA5, trial_cnt=8, busy low after the final consume.
REQ-037 sample of target 0x10 asserted in SETTLE -> ignored, response uses the old target; sample coincident with a handshake -> new target used, trial_cnt=0.
REQ-038 rst_n pulled low during RESP -> cmp_valid=0 immediately (asynchronous), trial_cnt=0, trial_ready=1.
REQ-039 CMP_DITHER_EN with target=0xFF, trial 0xFF -> cmp_out=1 on all of 16 trials (saturation); target=0x40, trial 0x41 -> cmp_out matches lfsr[0] sequence from seed 0x01.
